// File: rtl/bsg_arb_rr_one_hot_reg.sv
// Round-robin arbiter feeding a one-hot AND-OR mux into a single-entry valid/yumi output register.
// Optional packet locking (last_i port) is enabled by defining BSG_ARB_RR_PKT_LOCK_EN.
module bsg_arb_rr_one_hot_reg #(
  parameter int unsigned width_p = 41,
  parameter int unsigned els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
`ifdef BSG_ARB_RR_PKT_LOCK_EN
  input  logic [els_p-1:0]           last_i,
`endif
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [els_p-1:0]           grant_o,
  input  logic                       yumi_i
);

  localparam int unsigned lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [lg_els_lp-1:0] last_r;
  logic [lg_els_lp-1:0] grant_idx;
  logic [els_p-1:0]     scan_grant;
  logic [els_p-1:0]     grant;
  logic                 scan_hit;
  logic                 accept;
  logic                 load;
  logic                 ptr_upd;
  logic [width_p-1:0]   data_mux;

  // Scan from last_r+1 upward with wrap; first valid channel wins.
  always_comb begin
    scan_grant = '0;
    scan_hit   = 1'b0;
    for (int i = 1; i <= int'(els_p); i++) begin
      for (int k = 0; k < int'(els_p); k++) begin
        if (!scan_hit && v_i[k] && ((int'(last_r) + i) % int'(els_p) == k)) begin
          scan_grant[k] = 1'b1;
          scan_hit      = 1'b1;
        end
      end
    end
  end

`ifdef BSG_ARB_RR_PKT_LOCK_EN
  logic lock_r;
  logic last_beat;

  // While locked, grant_o still names the channel that opened the packet.
  assign grant     = lock_r ? (grant_o & v_i) : scan_grant;
  assign last_beat = |(grant & last_i);
  assign ptr_upd   = load & last_beat;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_r <= 1'b0;
    end else if (load) begin
      lock_r <= ~last_beat;
    end
  end
`else
  assign grant   = scan_grant;
  assign ptr_upd = load;
`endif

  assign accept = (~v_o | yumi_i) & ~reset_i;
  assign yumi_o = grant & {els_p{accept}};
  assign load   = |yumi_o;

  always_comb begin
    grant_idx = '0;
    data_mux  = '0;
    for (int k = 0; k < int'(els_p); k++) begin
      if (grant[k]) begin
        grant_idx = lg_els_lp'(k);
      end
      data_mux = data_mux | (data_i[k*width_p +: width_p] & {width_p{grant[k]}});
    end
  end

  generate
    if (els_p == 1) begin : g_single
      assign last_r = '0;
    end else begin : g_ptr
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          last_r <= lg_els_lp'(els_p - 1);
        end else if (ptr_upd) begin
          last_r <= grant_idx;
        end
      end
    end
  endgenerate

  // Output stage; yumi_i without a held beat is a protocol violation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_o     <= 1'b0;
      data_o  <= '0;
      grant_o <= '0;
    end else begin
      assert (v_o || !yumi_i);
      if (load) begin
        v_o     <= 1'b1;
        data_o  <= data_mux;
        grant_o <= grant;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_arb_rr_one_hot_reg.sv
// Bench for bsg_arb_rr_one_hot_reg: directed steps plus random traffic against a behavioural model.
// Exercises packet locking as well when BSG_ARB_RR_PKT_LOCK_EN is defined.
module tb_bsg_arb_rr_one_hot_reg;
  localparam int unsigned W = 41;
  localparam int unsigned N = 4;

  logic           clk;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   last_v;
  logic [N-1:0]   yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic [N-1:0]   grant_o;
  logic           yumi_i;

  bsg_arb_rr_one_hot_reg #(.width_p(W), .els_p(N)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
`ifdef BSG_ARB_RR_PKT_LOCK_EN
    .last_i  (last_v),
`endif
    .yumi_o  (yumi_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .grant_o (grant_o),
    .yumi_i  (yumi_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: output register contents, priority pointer and packet lock.
  logic [W-1:0] d [N];
  logic         m_v;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_last;
  logic         m_lock;
  int           m_lock_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    if (m_lock) return v[m_lock_ch] ? m_lock_ch : -1;
    for (int off = 1; off <= int'(N); off++) begin
      int ch;
      ch = (m_last + off) % int'(N);
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    yumi_i  = 1'b0;
    #1;
    chk("yumi_during_reset", 64'(yumi_o), 64'd0);
    @(posedge clk);
    #1;
    m_v = 1'b0; m_data = '0; m_ch = -1; m_last = int'(N) - 1; m_lock = 1'b0; m_lock_ch = 0;
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_data_o", 64'(data_o), 64'd0);
    chk("reset_grant_o", 64'(grant_o), 64'd0);
    reset_i = 1'b0;
  endtask

  // One clock: apply inputs, check yumi_o, clock, then check the output register.
  task automatic cycle(input logic [N-1:0] v, input logic y);
    int           ch;
    logic         yy;
    logic [N-1:0] exp_yumi;
    yy = y & m_v;
    v_i = v;
    yumi_i = yy;
    for (int k = 0; k < int'(N); k++) data_i[k*W +: W] = d[k];
    #1;
    ch = model_pick(v);
    exp_yumi = '0;
    if (ch >= 0 && (!m_v || yy)) exp_yumi[ch] = 1'b1;
    chk("yumi_o", 64'(yumi_o), 64'(exp_yumi));
    @(posedge clk);
    if (exp_yumi != '0) begin
      m_v = 1'b1;
      m_data = d[ch];
      m_ch = ch;
      if (last_v[ch]) begin
        m_last = ch;
        m_lock = 1'b0;
      end else begin
        m_lock = 1'b1;
        m_lock_ch = ch;
      end
    end else if (yy) begin
      m_v = 1'b0;
    end
    #1;
    chk("v_o", 64'(v_o), 64'(m_v));
    if (m_v) begin
      chk("data_o", 64'(data_o), 64'(m_data));
      chk("grant_o", 64'(grant_o), 64'(1) << m_ch);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    yumi_i  = 1'b0;
    v_i     = '0;
    data_i  = '0;
    last_v  = '1;
    for (int k = 0; k < int'(N); k++) d[k] = W'(64'h100 * (k + 1) + 64'h1_0000_0000 * k);
    do_reset();

    // All channels valid, downstream always ready: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1);
      chk("rr_order", 64'(grant_o), 64'(1) << (i % 4));
      chk("rr_data", 64'(data_o), 64'(d[i % 4]));
    end

    // Single beat from ch2 held while yumi_i is low.
    do_reset();
    d[2] = 41'h1_2345_6789;
    cycle(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b0);
      chk("hold_data", 64'(data_o), 64'h1_2345_6789);
      chk("hold_grant", 64'(grant_o), 64'b0100);
    end
    cycle(4'b0000, 1'b1);
    chk("drain_v_o", 64'(v_o), 64'd0);

    // Pointer wrap: after ch3, ch0 wins over ch3.
    cycle(4'b1000, 1'b1);
    cycle(4'b1001, 1'b1);
    chk("wrap_ch0", 64'(grant_o), 64'b0001);
    cycle(4'b1001, 1'b1);
    chk("wrap_ch3", 64'(grant_o), 64'b1000);

    // Load on the same cycle as drain: no bubble.
    d[1] = 41'h0_dead_beef;
    cycle(4'b0010, 1'b1);
    chk("nobubble_v", 64'(v_o), 64'd1);
    chk("nobubble_data", 64'(data_o), 64'h0_dead_beef);

    // Reset with a beat held and all channels requesting.
    cycle(4'b1111, 1'b1);
    v_i = 4'b1111;
    do_reset();
    cycle(4'b1111, 1'b1);
    chk("post_reset_ch0", 64'(grant_o), 64'b0001);

`ifdef BSG_ARB_RR_PKT_LOCK_EN
    // ch1 sends a 3-beat packet while ch0 keeps requesting.
    do_reset();
    last_v = 4'b1111;
    cycle(4'b0001, 1'b1);
    last_v = 4'b1101;
    cycle(4'b0011, 1'b1);
    chk("lock_beat1", 64'(grant_o), 64'b0010);
    cycle(4'b0011, 1'b1);
    chk("lock_beat2", 64'(grant_o), 64'b0010);
    last_v = 4'b1111;
    cycle(4'b0011, 1'b1);
    chk("lock_beat3", 64'(grant_o), 64'b0010);
    cycle(4'b0001, 1'b1);
    chk("lock_release", 64'(grant_o), 64'b0001);
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < int'(N); k++) d[k] = W'({$urandom(), $urandom()});
`ifdef BSG_ARB_RR_PKT_LOCK_EN
      last_v = N'($urandom());
`endif
      if ($urandom_range(0, 40) == 0) begin
        v_i = N'($urandom());
        do_reset();
      end else begin
        cycle(N'($urandom()), 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_arb_rr_one_hot_reg.md
Name: bsg_arb_rr_one_hot_reg

Overview:
- Upstream feeder for the one-hot AND-OR data mux stage.
- Round-robin arbitrates among els_p valid/ready input channels and forms a one-hot grant.
- Selects the granted channel's data with a one-hot AND-OR mux and registers the result into a single-entry output stage with a valid/yumi handshake.
- Sits between per-source request queues and the downstream consumer; grant_o identifies the source of the held beat.

Parameters:
- width_p, 41: data width per channel.
- els_p, 4: number of input channels; legal range 1..16.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  els_p  per-channel valid.
- data_i  input  els_p*width_p  channel k occupies bits [k*width_p +: width_p].
- yumi_o  output  els_p  one-hot; channel k's beat is consumed this cycle.
- v_o  output  1  output register holds a valid beat.
- data_o  output  width_p  registered data.
- grant_o  output  els_p  registered one-hot source of data_o.
- yumi_i  input  1  downstream consumes the beat this cycle; legal only when v_o=1.

Behaviour:
- Reset values (synchronous, reset_i=1 at the edge):
  - v_o=0, data_o=0, grant_o=0.
  - Priority pointer last_r=els_p-1, so channel 0 has highest priority after reset.
  - yumi_o=0 in any cycle in which reset_i=1.
- Accept condition: accept = ~v_o | yumi_i. The output register can load in the same cycle it is drained (full throughput, 1 beat/cycle).
- Arbitration (combinational):
  - Scan channels starting at (last_r+1) mod els_p, wrapping.
  - grant = one-hot of the first channel with v_i=1; grant=0 if no v_i is set.
- Handshake:
  - yumi_o = grant & {els_p{accept}}.
  - yumi_o depends on v_i, last_r, v_o and yumi_i only, never on data_i.
- Load (when |yumi_o):
  - data_o <= OR over k of (data_i[k] & {width_p{grant[k]}}).
  - grant_o <= grant; v_o <= 1; last_r <= index of grant.
- Drain only (yumi_i=1, no v_i set): v_o <= 0. data_o and grant_o keep their last values and are don't-care while v_o=0.
- Hold (v_o=1, yumi_i=0): data_o, grant_o and last_r are stable; yumi_o=0.
- Latency: 1 cycle from accepted input to v_o.
- Pointer wrap: after granting channel els_p-1, the next scan starts at channel 0.
- els_p=1: grant=v_i[0]; the pointer is a constant and has no register.
- Reset mid-transfer: any held beat is discarded (v_o=0 next cycle). The pointer returns to els_p-1.
- yumi_i while v_o=0 is a protocol error; an assertion fires in simulation. In hardware it has no effect beyond the accept term.

Optional Feature:
- Macro: BSG_ARB_RR_PKT_LOCK_EN.
- When defined:
  - Adds input port last_i [els_p], meaning channel k's current beat ends its packet.
  - After accepting a beat from channel k with last_i[k]=0, a lock register holds the grant on channel k until a beat with last_i[k]=1 is accepted. Other channels get no yumi_o during the lock.
  - last_r updates only on accepted beats with last_i=1.
  - Reset clears the lock.
- When undefined: the last_i port is absent and every beat is arbitrated independently.

Test Plan:
- After reset, v_i=4'b1111 with yumi_i held 1: grants in order ch0, ch1, ch2, ch3, ch0. v_o=1 from cycle 2 onward. data_o equals each channel's data.
- v_i=4'b0100, data ch2=41'h1_2345_6789 with yumi_i=0: yumi_o=4'b0100 for one cycle, then 0 while held. data_o=41'h1_2345_6789 and grant_o=4'b0100 stable until yumi_i.
- Last grant was ch3 and v_i=4'b1001: next grant is ch0 (wrap), then ch3.
- v_o=1 with yumi_i=1 and v_i=4'b0010 in the same cycle: ch1 is accepted with no bubble, v_o stays 1, data_o updates.
- Assert reset_i while v_o=1 and v_i=4'b1111: next cycle v_o=0 and yumi_o=0. After release, ch0 is granted first.
- With BSG_ARB_RR_PKT_LOCK_EN: ch1 sends 3 beats with last_i high on beat 3 while ch0 is continuously valid. yumi_o stays 4'b0010 for all 3 accepts, then ch0 is granted.
